rr_arbiter8way16: RTL



---
 rtl/rr_arbiter8way16.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/rr_arbiter8way16.sv
// Round-robin arbiter sharing one 16-bit bus among eight requesters,
// with a valid/ready handshake toward the sink and a per-grant burst cap.

module mux8way16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    input  logic [15:0] d,
    input  logic [15:0] e,
    input  logic [15:0] f,
    input  logic [15:0] g,
    input  logic [15:0] h,
    input  logic [2:0]  sel,
    output logic [15:0] out
);
    always_comb begin
        out = a;
        case (sel)
            3'd0: out = a;
            3'd1: out = b;
            3'd2: out = c;
            3'd3: out = d;
            3'd4: out = e;
            3'd5: out = f;
            3'd6: out = g;
            3'd7: out = h;
            default: out = a;
        endcase
    end
endmodule

module rr_arbiter8way16 #(
    parameter int MAX_BURST = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  req,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    input  logic [15:0] d,
    input  logic [15:0] e,
    input  logic [15:0] f,
    input  logic [15:0] g,
    input  logic [15:0] h,
    input  logic        out_ready,
    output logic [15:0] out,
    output logic        out_valid,
    output logic [7:0]  grant,
    output logic [7:0]  ack,
    output logic [2:0]  sel
);
    localparam int BW = $clog2(MAX_BURST) + 1;
    localparam logic [BW-1:0] BLAST = BW'(MAX_BURST - 1);
    localparam logic [BW-1:0] BONE = BW'(1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state_q, state_d;
    logic [2:0]    sel_q, sel_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [15:0]   mux_out;
    logic [7:0]    sel_oh;
    logic [7:0]    m;
    logic          hs;
    logic          rearb;

    // First set bit of mask scanning upward from start, wrapping mod 8.
    function automatic logic [2:0] rr_pick(
        input logic [2:0] start,
        input logic [7:0] mask
    );
        logic [2:0] idx;
        logic [2:0] pick;
        pick = start;
        for (int k = 7; k >= 0; k--) begin
            idx = start + 3'(k);
            if (mask[idx]) pick = idx;
        end
        return pick;
    endfunction

    mux8way16 u_mux (
        .a(a), .b(b), .c(c), .d(d),
        .e(e), .f(f), .g(g), .h(h),
        .sel(sel_q),
        .out(mux_out)
    );

    assign sel_oh    = 8'b1 << sel_q;
    assign out_valid = (state_q == GRANT) & req[sel_q];
    assign out       = out_valid ? mux_out : 16'h0000;
    assign grant     = (state_q == GRANT) ? sel_oh : 8'h00;
    assign hs        = out_valid & out_ready;
    assign ack       = hs ? sel_oh : 8'h00;
    assign sel       = sel_q;
    assign m         = req & ~sel_oh;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        bcnt_d  = bcnt_q;
        rearb   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    sel_d   = rr_pick(ptr_q + 3'd1, req);
                    bcnt_d  = '0;
                end
            end
            GRANT: begin
                if (hs) begin
                    ptr_d = sel_q;
                    if (bcnt_q != BLAST) bcnt_d = bcnt_q + BONE;
                    else rearb = 1'b1;
                end else if (!req[sel_q]) begin
                    // A withdrawal before any word leaves the pointer alone.
                    if (bcnt_q != '0) ptr_d = sel_q;
                    rearb = 1'b1;
                end
                if (rearb) begin
                    bcnt_d = '0;
                    if (|m) sel_d = rr_pick(sel_q + 3'd1, m);
                    else state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= 3'd0;
            ptr_q   <= 3'd7;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            bcnt_q  <= bcnt_d;
        end
    end
endmodule
